// File: rtl/alu_nibble_seq_pkg.sv
// Shared types for the nibble-serial ALU controller.
// Op and state encodings plus small decode helpers.
package alu_nibble_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Add and sub chain a carry; the logic ops do not.
  function automatic logic is_arith(op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Sub feeds the inverted B nibble into the adder.
  function automatic logic [NIB_W-1:0] b_prime(
    op_e              op,
    logic [NIB_W-1:0] b
  );
    return (op == OP_SUB) ? ~b : b;
  endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice shared across all passes.
// Add/sub both add here; B is pre-inverted by the caller for sub.
module alu_nibble_slice
  import alu_nibble_seq_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             ci_i,
  output logic [NIB_W-1:0] y_o,
  output logic             co_o
);

  logic [NIB_W:0] sum;

  // Nibble add with carry, or bitwise logic with a zero carry.
  always_comb begin
    sum  = {1'b0, a_i} + {1'b0, b_i} + {{NIB_W{1'b0}}, ci_i};
    y_o  = '0;
    co_o = 1'b0;
    unique case (op_i)
      OP_ADD,
      OP_SUB: begin
        y_o  = sum[NIB_W-1:0];
        co_o = sum[NIB_W];
      end
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      default: begin
        y_o  = '0;
        co_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial 16-bit ALU: one 4-bit slice run LSB first.
// Define ALU_SEQ_OVF_FLAG_EN to add the signed overflow output ovf.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic [4*NIBBLES-1:0] result,
  output logic                 co,
  output logic                 zero,
  output logic                 busy,
  output logic                 done
`ifdef ALU_SEQ_OVF_FLAG_EN
  ,
  output logic                 ovf
`endif
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW =
    (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  op_e             op_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic            co_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] slice_y;
  logic             slice_co;

  // Current nibble of each latched operand.
  assign a_nib = a_q[NIB_W*idx_q +: NIB_W];
  assign b_nib = b_prime(op_q, b_q[NIB_W*idx_q +: NIB_W]);

  alu_nibble_slice u_slice (
    .a_i  (a_nib),
    .b_i  (b_nib),
    .op_i (op_q),
    .ci_i (carry_q),
    .y_o  (slice_y),
    .co_o (slice_co)
  );

`ifdef ALU_SEQ_OVF_FLAG_EN
  logic vraw_q;
  logic ovf_q;
  logic msb_cin;

  // Carry into the top bit, recovered from its sum bit.
  assign msb_cin = a_nib[NIB_W-1] ^ b_nib[NIB_W-1] ^ slice_y[NIB_W-1];

  // Captures overflow on the last pass; published with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      vraw_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state_q == S_RUN && idx_q == IDX_LAST) begin
        vraw_q <= is_arith(op_q) & (msb_cin ^ slice_co);
      end
      if (state_q == S_DONE) begin
        ovf_q <= vraw_q;
      end
    end
  end

  assign ovf = ovf_q;
`endif

  // Controller FSM with operand, result and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      co_q     <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_e'(op);
            idx_q   <= '0;
            carry_q <= (op == OP_SUB);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[NIB_W*idx_q +: NIB_W] <= slice_y;
          carry_q <= slice_co;
          idx_q   <= idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          co_q    <= carry_q & is_arith(op_q);
          zero_q  <= (result_q == '0);
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign result = result_q;
  assign co     = co_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq.
// Reference model uses plain 16-bit integer arithmetic.
module tb_alu_nibble_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] result;
  logic         co;
  logic         zero;
  logic         busy;
  logic         done;
`ifdef ALU_SEQ_OVF_FLAG_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .co     (co),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
`ifdef ALU_SEQ_OVF_FLAG_EN
    ,
    .ovf    (ovf)
`endif
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         zero;
    logic         ovf;
  } exp_t;

  function automatic exp_t model(logic [1:0] o, logic [W-1:0] x,
                                 logic [W-1:0] y);
    exp_t e;
    int   ux, uy, sx, sy, ur, sr;
    e  = '0;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    case (o)
      2'b00: begin
        ur    = ux + uy;
        sr    = sx + sy;
        e.res = ur[W-1:0];
        e.co  = (ur > 65535);
        e.ovf = (sr > 32767) || (sr < -32768);
      end
      2'b01: begin
        ur    = ux - uy;
        sr    = sx - sy;
        e.res = ur[W-1:0];
        e.co  = (ux >= uy);
        e.ovf = (sr > 32767) || (sr < -32768);
      end
      2'b10: e.res = x & y;
      default: e.res = x | y;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic launch(logic [1:0] o, logic [W-1:0] x,
                        logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
  endtask

  // Samples the cycles after the accept edge; done due on the 5th.
  task automatic watch(logic [1:0] o, logic [W-1:0] x,
                       logic [W-1:0] y, bit hold, bit poke);
    exp_t e;
    e = model(o, x, y);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      if (poke && k == 1) begin
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
        op    = 2'($urandom);
      end
      if (poke && k == 2) start = 1'b0;
      if (k < 5) begin
        chk("busy_run", 32'(busy), 32'd1);
        chk("done_early", 32'(done), 32'd0);
      end else begin
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("result", 32'(result), 32'(e.res));
        chk("co", 32'(co), 32'(e.co));
        chk("zero", 32'(zero), 32'(e.zero));
`ifdef ALU_SEQ_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  endtask

  task automatic run(logic [1:0] o, logic [W-1:0] x,
                     logic [W-1:0] y);
    launch(o, x, y);
    watch(o, x, y, 1'b0, 1'b0);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef ALU_SEQ_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;

    run(2'b00, 16'h1234, 16'h0FFF);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    run(2'b00, 16'hFFFF, 16'h0001);
    run(2'b01, 16'h0005, 16'h0007);
    run(2'b01, 16'h0007, 16'h0005);
    run(2'b10, 16'hF0F0, 16'h3C3C);
    run(2'b11, 16'hF0F0, 16'h0C0C);

    // Start and operand changes during RUN must be ignored.
    launch(2'b00, 16'h1234, 16'h0FFF);
    watch(2'b00, 16'h1234, 16'h0FFF, 1'b0, 1'b1);
    @(negedge clk);
    chk("no_queue_busy", 32'(busy), 32'd0);

    // Held start gives back-to-back operations.
    launch(2'b01, 16'hABCD, 16'h1111);
    watch(2'b01, 16'hABCD, 16'h1111, 1'b1, 1'b0);
    op = 2'b11;
    a  = 16'h0102;
    b  = 16'h2010;
    @(posedge clk);
    watch(2'b11, 16'h0102, 16'h2010, 1'b0, 1'b0);

    // Reset in the second RUN cycle aborts with no done.
    launch(2'b10, 16'hFFFF, 16'hFFFF);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      run(ro, ra, rb);
    end

    run(2'b00, 16'h7FFF, 16'h0001);
    run(2'b01, 16'h8000, 16'h0001);
    run(2'b01, 16'h4321, 16'h4321);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
